// File: rtl/pulse_train_ch1.sv
`default_nettype none
// ============================================================================
// Module   : pulse_train_ch1
// Purpose  : Channel-1 optical sync pulse train generator, launched by the
//            delay stage strobe; N pulses of programmable width and period.
// Revision : 1.0  initial release
// ============================================================================
module pulse_train_ch1 #(
    parameter int CNT_W = 36,
    parameter int NP_W  = 8
) (
    input  logic             clk_PL,
    input  logic             rst_PL,
    input  logic             PL_launch,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] period,
    input  logic [NP_W-1:0]  n_pulses,
    output logic             PL_out,
    output logic             PL_busy,
    output logic             PL_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NP_W-1:0]  C_NP_ONE  = {{(NP_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic             launch_prev_q;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NP_W-1:0]  rem_q, rem_d;

    logic             w_start;
    logic [CNT_W-1:0] w_gap;

    // armed_q stays low after reset until the strobe is seen low, so a strobe
    // held high across reset cannot masquerade as a fresh rising edge.
    assign w_start = PL_launch & ~launch_prev_q & armed_q;
    assign w_gap   = (period > width) ? (period - width) : C_CNT_ONE;

    always_ff @(posedge clk_PL) begin
        if (rst_PL) begin
            state_q       <= S_IDLE;
            launch_prev_q <= 1'b0;
            armed_q       <= 1'b0;
            width_q       <= '0;
            gap_q         <= '0;
            cnt_q         <= '0;
            rem_q         <= '0;
        end else begin
            state_q       <= state_d;
            launch_prev_q <= PL_launch;
            armed_q       <= armed_d;
            width_q       <= width_d;
            gap_q         <= gap_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q | ~PL_launch;
        width_d = width_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    width_d = width;
                    gap_d   = w_gap;
                    if ((width == '0) || (n_pulses == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HIGH;
                        cnt_d   = width - C_CNT_ONE;
                        rem_d   = n_pulses - C_NP_ONE;
                    end
                end
            end
            S_HIGH: begin
                // A dropped strobe wins over a counter expiring on the same edge.
                if (!PL_launch) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    if (rem_q != '0) begin
                        state_d = S_LOW;
                        cnt_d   = gap_q - C_CNT_ONE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            S_LOW: begin
                if (!PL_launch) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_HIGH;
                    cnt_d   = width_q - C_CNT_ONE;
                    rem_d   = rem_q - C_NP_ONE;
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            S_DONE: begin
                if (!PL_launch) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        PL_out  = (state_q == S_HIGH);
        PL_busy = (state_q == S_HIGH) || (state_q == S_LOW);
        PL_done = (state_q == S_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_ch1.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_train_ch1
// Purpose  : Directed self-checking bench for pulse_train_ch1.
// Revision : 1.0  initial release
// ============================================================================
module tb_pulse_train_ch1;

    localparam int CNT_W = 36;
    localparam int NP_W  = 8;

    logic             clk_PL    = 1'b0;
    logic             rst_PL    = 1'b1;
    logic             PL_launch = 1'b0;
    logic [CNT_W-1:0] width     = '0;
    logic [CNT_W-1:0] period    = '0;
    logic [NP_W-1:0]  n_pulses  = '0;
    logic             PL_out;
    logic             PL_busy;
    logic             PL_done;

    int errors   = 0;
    int checks   = 0;
    int busy_acc = 0;

    pulse_train_ch1 #(.CNT_W(CNT_W), .NP_W(NP_W)) dut (
        .clk_PL    (clk_PL),
        .rst_PL    (rst_PL),
        .PL_launch (PL_launch),
        .width     (width),
        .period    (period),
        .n_pulses  (n_pulses),
        .PL_out    (PL_out),
        .PL_busy   (PL_busy),
        .PL_done   (PL_done)
    );

    always #5 clk_PL = ~clk_PL;

    task automatic tick();
        @(posedge clk_PL);
        #1;
    endtask

    // Length of the current run of PL_out at level lvl, bounded by limit.
    task automatic count_run(input logic lvl, input int limit, output int n);
        n = 0;
        while ((PL_out === lvl) && (n < limit)) begin
            if (PL_busy === 1'b1) busy_acc++;
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_PL = 1'b1; PL_launch = 1'b0;
        tick(); tick();
        checks++; if ({PL_out, PL_busy, PL_done} !== 3'b000) begin errors++; $display("FAIL reset_outs: got %b want 000", {PL_out, PL_busy, PL_done}); end
        rst_PL = 1'b0;
        tick();
        checks++; if ({PL_out, PL_busy, PL_done} !== 3'b000) begin errors++; $display("FAIL reset_idle: got %b want 000", {PL_out, PL_busy, PL_done}); end
    endtask

    task automatic test_basic();
        int exp_len[5] = '{5, 7, 5, 7, 5};
        int n;
        width = 36'd5; period = 36'd12; n_pulses = 8'd3;
        busy_acc = 0;
        PL_launch = 1'b1;
        tick();
        checks++; if ({PL_out, PL_busy} !== 2'b11) begin errors++; $display("FAIL basic_first_edge: got out/busy %b want 11", {PL_out, PL_busy}); end
        for (int i = 0; i < 5; i++) begin
            count_run((i % 2) == 0, 200, n);
            checks++; if (n !== exp_len[i]) begin errors++; $display("FAIL basic_run%0d: got %0d cycles want %0d", i, n, exp_len[i]); end
        end
        checks++; if (busy_acc !== 29) begin errors++; $display("FAIL basic_busy_len: got %0d want 29", busy_acc); end
        repeat (3) tick();
        checks++; if ({PL_out, PL_busy, PL_done} !== 3'b001) begin errors++; $display("FAIL basic_done_hold: got %b want 001", {PL_out, PL_busy, PL_done}); end
        PL_launch = 1'b0;
        tick();
        checks++; if (PL_done !== 1'b0) begin errors++; $display("FAIL basic_done_clear: got %b want 0", PL_done); end
        PL_launch = 1'b1;
        tick();
        checks++; if ({PL_out, PL_busy} !== 2'b11) begin errors++; $display("FAIL basic_rearm: got out/busy %b want 11", {PL_out, PL_busy}); end
        PL_launch = 1'b0;
        tick();
        checks++; if ({PL_out, PL_busy, PL_done} !== 3'b000) begin errors++; $display("FAIL basic_abort_idle: got %b want 000", {PL_out, PL_busy, PL_done}); end
        tick();
    endtask

    task automatic test_clamp();
        int exp_len[3] = '{4, 1, 4};
        int n;
        width = 36'd4; period = 36'd3; n_pulses = 8'd2;
        PL_launch = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            count_run((i % 2) == 0, 100, n);
            checks++; if (n !== exp_len[i]) begin errors++; $display("FAIL clamp_run%0d: got %0d cycles want %0d", i, n, exp_len[i]); end
        end
        checks++; if ({PL_out, PL_busy, PL_done} !== 3'b001) begin errors++; $display("FAIL clamp_done: got %b want 001", {PL_out, PL_busy, PL_done}); end
        PL_launch = 1'b0;
        tick();
    endtask

    task automatic test_zero();
        logic seen;
        for (int k = 0; k < 2; k++) begin
            width    = (k == 0) ? 36'd0 : 36'd5;
            period   = 36'd10;
            n_pulses = (k == 0) ? 8'd3 : 8'd0;
            PL_launch = 1'b1;
            tick();
            checks++; if ({PL_out, PL_busy, PL_done} !== 3'b001) begin errors++; $display("FAIL zero%0d_done: got %b want 001", k, {PL_out, PL_busy, PL_done}); end
            seen = 1'b0;
            repeat (4) begin
                tick();
                seen = seen | PL_out | PL_busy;
            end
            checks++; if (seen !== 1'b0) begin errors++; $display("FAIL zero%0d_quiet: got out|busy %b want 0", k, seen); end
            PL_launch = 1'b0;
            tick();
            checks++; if (PL_done !== 1'b0) begin errors++; $display("FAIL zero%0d_clear: got %b want 0", k, PL_done); end
        end
    endtask

    task automatic test_abort();
        int n;
        width = 36'd100; period = 36'd200; n_pulses = 8'd1;
        PL_launch = 1'b1;
        tick();
        repeat (39) tick();
        checks++; if (PL_out !== 1'b1) begin errors++; $display("FAIL abort_cycle40: got %b want 1", PL_out); end
        PL_launch = 1'b0;
        tick();
        checks++; if ({PL_out, PL_busy, PL_done} !== 3'b000) begin errors++; $display("FAIL abort_next: got %b want 000", {PL_out, PL_busy, PL_done}); end
        tick();
        checks++; if (PL_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", PL_done); end
        PL_launch = 1'b1;
        tick();
        count_run(1'b1, 300, n);
        checks++; if (n !== 100) begin errors++; $display("FAIL abort_full_pulse: got %0d cycles want 100", n); end
        checks++; if ({PL_out, PL_busy, PL_done} !== 3'b001) begin errors++; $display("FAIL abort_then_done: got %b want 001", {PL_out, PL_busy, PL_done}); end
        PL_launch = 1'b0;
        tick();
    endtask

    task automatic test_reprogram();
        int exp_len[5] = '{5, 7, 5, 7, 5};
        int n;
        width = 36'd5; period = 36'd12; n_pulses = 8'd3;
        PL_launch = 1'b1;
        tick();
        width = 36'd9; period = 36'd20; n_pulses = 8'd1;
        for (int i = 0; i < 5; i++) begin
            count_run((i % 2) == 0, 200, n);
            checks++; if (n !== exp_len[i]) begin errors++; $display("FAIL reprog_run%0d: got %0d cycles want %0d", i, n, exp_len[i]); end
        end
        checks++; if (PL_done !== 1'b1) begin errors++; $display("FAIL reprog_done: got %b want 1", PL_done); end
        PL_launch = 1'b0;
        width = 36'd5; period = 36'd12; n_pulses = 8'd3;
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen;
        PL_launch = 1'b1;
        tick();
        count_run(1'b1, 100, n);
        checks++; if (n !== 5) begin errors++; $display("FAIL rstmid_pulse: got %0d cycles want 5", n); end
        tick(); tick();
        checks++; if ({PL_out, PL_busy} !== 2'b01) begin errors++; $display("FAIL rstmid_in_low: got out/busy %b want 01", {PL_out, PL_busy}); end
        rst_PL = 1'b1;
        tick();
        checks++; if ({PL_out, PL_busy, PL_done} !== 3'b000) begin errors++; $display("FAIL rstmid_outs: got %b want 000", {PL_out, PL_busy, PL_done}); end
        rst_PL = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | PL_out | PL_busy | PL_done;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_retrigger: got activity %b want 0", seen); end
        PL_launch = 1'b0;
        tick();
        PL_launch = 1'b1;
        tick();
        checks++; if ({PL_out, PL_busy} !== 2'b11) begin errors++; $display("FAIL rstmid_rearm: got out/busy %b want 11", {PL_out, PL_busy}); end
        PL_launch = 1'b0;
        tick();
        checks++; if ({PL_out, PL_busy, PL_done} !== 3'b000) begin errors++; $display("FAIL rstmid_abort: got %b want 000", {PL_out, PL_busy, PL_done}); end
        tick();
    endtask

    task automatic test_long();
        int exp_len[3] = '{16384, 16384, 16384};
        int n;
        width = 36'd16384; period = 36'd32768; n_pulses = 8'd2;
        PL_launch = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            count_run((i % 2) == 0, 20000, n);
            checks++; if (n !== exp_len[i]) begin errors++; $display("FAIL long_run%0d: got %0d cycles want %0d", i, n, exp_len[i]); end
        end
        checks++; if ({PL_out, PL_busy, PL_done} !== 3'b001) begin errors++; $display("FAIL long_done: got %b want 001", {PL_out, PL_busy, PL_done}); end
        PL_launch = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_zero();
        test_abort();
        test_reprogram();
        test_reset_mid();
        test_long();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
